exe_mem_stage_reg: RTL and testbench
====================================

Name: exe_mem_stage_reg

Overview:
- Sequential stage directly downstream of the execute-stage ALU. Provides the EX/MEM pipeline register and the architectural NZCV status register.
- Latches the ALU result, flags and memory/write-back controls into the MEM stage.
- Updates NZCV when the executing instruction has its S bit set.
- Feeds the stored carry back to the ALU as C_in, and evaluates the 4-bit condition field of the instruction in ID against the stored flags.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data).
- REG_ADDR_W, 4, register-file address width (destination register).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- freeze  input  1  MEM-stage stall; hold all state
- flush  input  1  kill the instruction currently in EX
- valid_in  input  1  EX holds a real instruction
- wb_en_in  input  1  write-back enable from EX
- mem_r_en_in  input  1  load from EX
- mem_w_en_in  input  1  store from EX
- s_in  input  1  update status flags
- dest_in  input  REG_ADDR_W  destination register
- alu_res_in  input  DATA_W  ALU result / memory address
- val_rm_in  input  DATA_W  store data
- n_in, z_in, c_in_flag, v_in  input  1 each  ALU flags
- cond_id  input  4  condition field of the instruction in ID
- valid_out  output  1  MEM holds a real instruction
- wb_en_out, mem_r_en_out, mem_w_en_out  output  1 each  registered controls
- dest_out  output  REG_ADDR_W  registered destination
- alu_res_out  output  DATA_W  registered result
- val_rm_out  output  DATA_W  registered store data
- status_out  output  4  NZCV as {N,Z,C,V}
- alu_c_in  output  1  carry to ALU; equals status_out[1]
- cond_pass  output  1  cond_id satisfied

Behaviour:
- Reset: all outputs are 0, NZCV = 0000, and cond_pass is driven from the zeroed flags. This is sampled on the clk edge only (synchronous).
- Priority per edge is rst > freeze > flush > capture.
- freeze=1: every register holds its value, including NZCV. flush is ignored while frozen; the upstream branch logic holds flush until freeze drops.
- flush=1 (not frozen):
  - valid_out, wb_en_out, mem_r_en_out and mem_w_en_out are set to 0; data fields are set to 0.
  - NZCV is not updated.
- Capture:
  - All *_out take their *_in values on the next edge, giving 1-cycle latency.
  - Controls are ANDed with valid_in, so an invalid instruction never asserts an enable.
- NZCV update: on a capture edge, NZCV <= {n_in, z_in, c_in_flag, v_in} only if valid_in && s_in. Otherwise NZCV holds.
- alu_c_in is combinational from the NZCV register. There is no combinational path from the c_in_flag input.
- cond_pass is combinational from cond_id and NZCV, following the ARM table:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0 (reserved, never passes)
- Reset asserted mid-stall or mid-flush clears everything in the same edge.

Optional Feature:
- SR_BYPASS_EN defined:
  - cond_pass and alu_c_in use the flags being written this cycle whenever valid_in && s_in && !freeze && !flush.
  - This lets a conditional instruction directly behind an S instruction issue without a stall.
- Undefined: both signals use registered NZCV only, and the hazard unit stalls as needed.

Decomposition:
- Shared package:
  - cond-code constants COND_EQ through COND_AL
  - NZCV bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0
- One sub-module, cond_check: combinational, inputs cond[3:0] and nzcv[3:0], output pass. It is reused by the branch unit.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> all outputs 0, status_out=0000; with cond_id=1110, cond_pass=1.
- Capture and S update: valid_in=1, s_in=1, alu_res_in=0x80000000, n=1, z=0, c=1, v=0 -> next cycle alu_res_out=0x80000000, status_out=1010, alu_c_in=1; cond_id=0100 (MI) -> cond_pass=1.
- No S: valid_in=1, s_in=0, flags 0100 -> status_out keeps its prior value 1010; alu_res_out still updates.
- Freeze vs flush: with freeze=1 and flush=1 for 3 cycles while inputs change -> outputs and status frozen; freeze=0 with flush=1 -> valid_out=0, mem_w_en_out=0, status unchanged.
- Condition sweep: load each NZCV value 0000–1111 via S updates and sweep cond_id 0000–1111 -> cond_pass matches the table for all 256 combinations (e.g. NZCV=1001, GE=1, LT=0).
- Invalid instruction: valid_in=0 with wb_en_in=1, mem_w_en_in=1, s_in=1 -> wb_en_out=0, mem_w_en_out=0, NZCV unchanged.

Source files
------------

// File: rtl/exe_mem_stage_reg_pkg.sv
// Shared definitions for the EX/MEM stage register and condition evaluation.
// Holds the ARM condition-code encodings and the NZCV bit positions used by
// the stage register, cond_check and the branch unit.
package exe_mem_stage_reg_pkg;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned COND_W = 4;

    // Bit positions inside the {N,Z,C,V} status vector
    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    // Condition-field encodings; 4'b1111 is reserved and never passes
    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;

endpackage

// File: rtl/exe_mem_stage_reg_cond_check.sv
// cond_check: combinational ARM condition evaluator, shared with the branch unit.
// Ports:
//   cond [3:0] - condition field of the instruction
//   nzcv [3:0] - status flags {N,Z,C,V}
//   pass       - 1 when the condition is satisfied
module cond_check
    import exe_mem_stage_reg_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [NZCV_W-1:0] nzcv,
    output logic              pass
);

    logic n, z, c, v;

    assign n = nzcv[N_BIT];
    assign z = nzcv[Z_BIT];
    assign c = nzcv[C_BIT];
    assign v = nzcv[V_BIT];

    // Reserved encoding falls to the default and never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// exe_mem_stage_reg: EX/MEM pipeline register plus the architectural NZCV register.
// Captures ALU result, store data, destination and MEM/WB controls with one
// cycle of latency; updates NZCV on valid S-bit instructions; feeds carry back
// to the ALU and evaluates the ID-stage condition field against the flags.
// Priority per edge: rst > freeze > flush > capture (rst is synchronous).
// Optional macro SR_BYPASS_EN: alu_c_in and cond_pass see the flags being
// written this cycle instead of waiting for the registered copy.
// Ports:
//   clk, rst, freeze, flush           - clock, sync reset, MEM stall, EX kill
//   valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in, dest_in,
//   alu_res_in, val_rm_in, n_in, z_in, c_in_flag, v_in - EX-stage inputs
//   cond_id                           - condition field of the instruction in ID
//   valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out,
//   alu_res_out, val_rm_out           - registered MEM-stage outputs
//   status_out                        - NZCV {N,Z,C,V}
//   alu_c_in, cond_pass               - combinational from the flags
module exe_mem_stage_reg
    import exe_mem_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  s_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic                  n_in,
    input  logic                  z_in,
    input  logic                  c_in_flag,
    input  logic                  v_in,
    input  logic [COND_W-1:0]     cond_id,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [DATA_W-1:0]     alu_res_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic [NZCV_W-1:0]     status_out,
    output logic                  alu_c_in,
    output logic                  cond_pass
);

    logic                  valid_q,    valid_d;
    logic                  wb_en_q,    wb_en_d;
    logic                  mem_r_en_q, mem_r_en_d;
    logic                  mem_w_en_q, mem_w_en_d;
    logic [REG_ADDR_W-1:0] dest_q,     dest_d;
    logic [DATA_W-1:0]     alu_res_q,  alu_res_d;
    logic [DATA_W-1:0]     val_rm_q,   val_rm_d;
    logic [NZCV_W-1:0]     nzcv_q,     nzcv_d;

    logic [NZCV_W-1:0]     flags_in;
    logic                  nzcv_wr;
    logic [NZCV_W-1:0]     nzcv_eff;

    assign flags_in = {n_in, z_in, c_in_flag, v_in};
    assign nzcv_wr  = valid_in && s_in && !freeze && !flush;

    // Next-state: hold by default; flush clears; capture gates controls with valid_in
    always_comb begin
        valid_d    = valid_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        dest_d     = dest_q;
        alu_res_d  = alu_res_q;
        val_rm_d   = val_rm_q;
        nzcv_d     = nzcv_q;
        if (!freeze) begin
            if (flush) begin
                valid_d    = 1'b0;
                wb_en_d    = 1'b0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
                dest_d     = '0;
                alu_res_d  = '0;
                val_rm_d   = '0;
            end else begin
                valid_d    = valid_in;
                wb_en_d    = wb_en_in    && valid_in;
                mem_r_en_d = mem_r_en_in && valid_in;
                mem_w_en_d = mem_w_en_in && valid_in;
                dest_d     = dest_in;
                alu_res_d  = alu_res_in;
                val_rm_d   = val_rm_in;
            end
        end
        if (nzcv_wr) begin
            nzcv_d = flags_in;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            dest_q     <= '0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            nzcv_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            dest_q     <= dest_d;
            alu_res_q  <= alu_res_d;
            val_rm_q   <= val_rm_d;
            nzcv_q     <= nzcv_d;
        end
    end

`ifdef SR_BYPASS_EN
    // Forward in-flight flags so a conditional right behind an S op need not stall
    assign nzcv_eff = nzcv_wr ? flags_in : nzcv_q;
`else
    assign nzcv_eff = nzcv_q;
`endif

    cond_check u_cond_check (
        .cond (cond_id),
        .nzcv (nzcv_eff),
        .pass (cond_pass)
    );

    assign alu_c_in     = nzcv_eff[C_BIT];
    assign valid_out    = valid_q;
    assign wb_en_out    = wb_en_q;
    assign mem_r_en_out = mem_r_en_q;
    assign mem_w_en_out = mem_w_en_q;
    assign dest_out     = dest_q;
    assign alu_res_out  = alu_res_q;
    assign val_rm_out   = val_rm_q;
    assign status_out   = nzcv_q;

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Directed self-checking bench for exe_mem_stage_reg.
module tb_exe_mem_stage_reg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 4;

    logic                  clk = 1'b0;
    logic                  rst, freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
    logic [REG_ADDR_W-1:0] dest_in;
    logic [DATA_W-1:0]     alu_res_in, val_rm_in;
    logic                  n_in, z_in, c_in_flag, v_in;
    logic [3:0]            cond_id;
    logic                  valid_out, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [REG_ADDR_W-1:0] dest_out;
    logic [DATA_W-1:0]     alu_res_out, val_rm_out;
    logic [3:0]            status_out;
    logic                  alu_c_in, cond_pass;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_mem_stage_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .s_in(s_in), .dest_in(dest_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .n_in(n_in), .z_in(z_in), .c_in_flag(c_in_flag), .v_in(v_in),
        .cond_id(cond_id), .valid_out(valid_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .dest_out(dest_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
        .status_out(status_out), .alu_c_in(alu_c_in), .cond_pass(cond_pass)
    );

    // Expected condition result, grouped by condition pair: even code tests, odd inverts
    function automatic logic exp_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !b : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {n_in, z_in, c_in_flag, v_in} = f;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; s_in = 1'b1;
        dest_in = 4'hA; alu_res_in = 32'hCAFE_F00D; val_rm_in = 32'h1234_5678;
        set_flags(4'b1100); cond_id = 4'b1110;
        tick(); tick();
        total++;
        if ({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out});
        end
        total++;
        if (dest_out !== 4'h0 || alu_res_out !== 32'h0 || val_rm_out !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0/0/0", dest_out, alu_res_out, val_rm_out);
        end
        total++;
        if (status_out !== 4'b0000) begin
            bad++; $display("FAIL reset_status got=%b want=0000", status_out);
        end
        total++;
        if (alu_c_in !== 1'b0) begin
            bad++; $display("FAIL reset_alu_c_in got=%b want=0", alu_c_in);
        end
        total++;
        if (cond_pass !== 1'b1) begin
            bad++; $display("FAIL reset_cond_al got=%b want=1", cond_pass);
        end
        rst = 1'b0;
    endtask

    task automatic test_capture_s();
        valid_in = 1'b1; s_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
        dest_in = 4'h5; alu_res_in = 32'h8000_0000; val_rm_in = 32'hDEAD_BEEF;
        set_flags(4'b1010); cond_id = 4'b0000;
        #1;
        total++;
        if (alu_res_out !== 32'h0) begin
            bad++; $display("FAIL capture_latency got=%h want=00000000", alu_res_out);
        end
        tick();
        valid_in = 1'b0; s_in = 1'b0;
        total++;
        if (alu_res_out !== 32'h8000_0000 || val_rm_out !== 32'hDEAD_BEEF || dest_out !== 4'h5) begin
            bad++; $display("FAIL capture_data got=%h/%h/%h want=80000000/deadbeef/5", alu_res_out, val_rm_out, dest_out);
        end
        total++;
        if ({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out} !== 4'b1101) begin
            bad++; $display("FAIL capture_ctrl got=%b want=1101", {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out});
        end
        total++;
        if (status_out !== 4'b1010 || alu_c_in !== 1'b1) begin
            bad++; $display("FAIL capture_status got=%b c=%b want=1010 c=1", status_out, alu_c_in);
        end
        cond_id = 4'b0100;
        #1;
        total++;
        if (cond_pass !== 1'b1) begin
            bad++; $display("FAIL capture_cond_mi got=%b want=1", cond_pass);
        end
    endtask

    task automatic test_no_s();
        valid_in = 1'b1; s_in = 1'b0; wb_en_in = 1'b0; mem_w_en_in = 1'b1;
        alu_res_in = 32'h1234_5678; set_flags(4'b0100);
        tick();
        total++;
        if (status_out !== 4'b1010 || alu_c_in !== 1'b1) begin
            bad++; $display("FAIL no_s_status got=%b c=%b want=1010 c=1", status_out, alu_c_in);
        end
        total++;
        if (alu_res_out !== 32'h1234_5678 || mem_w_en_out !== 1'b1) begin
            bad++; $display("FAIL no_s_data got=%h w=%b want=12345678 w=1", alu_res_out, mem_w_en_out);
        end
    endtask

    task automatic test_freeze_flush();
        freeze = 1'b1; flush = 1'b1; valid_in = 1'b1; s_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_res_in = 32'hA000_0000 + 32'(i); set_flags(4'(i + 3)); mem_w_en_in = 1'b0;
            tick();
            total++;
            if (alu_res_out !== 32'h1234_5678 || status_out !== 4'b1010 ||
                valid_out !== 1'b1 || mem_w_en_out !== 1'b1) begin
                bad++; $display("FAIL freeze_hold[%0d] got=%h/%b/%b/%b want=12345678/1010/1/1",
                                i, alu_res_out, status_out, valid_out, mem_w_en_out);
            end
        end
        freeze = 1'b0; mem_w_en_in = 1'b1; wb_en_in = 1'b1; set_flags(4'b0101);
        tick();
        flush = 1'b0; valid_in = 1'b0; s_in = 1'b0;
        total++;
        if ({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out} !== 4'b0000 || alu_res_out !== 32'h0) begin
            bad++; $display("FAIL flush_clear got=%b res=%h want=0000 res=0",
                            {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out}, alu_res_out);
        end
        total++;
        if (status_out !== 4'b1010) begin
            bad++; $display("FAIL flush_status got=%b want=1010", status_out);
        end
    endtask

    task automatic test_cond_sweep();
        for (int f = 0; f < 16; f++) begin
            valid_in = 1'b1; s_in = 1'b1; set_flags(4'(f));
            tick();
            valid_in = 1'b0; s_in = 1'b0;
            total++;
            if (status_out !== 4'(f)) begin
                bad++; $display("FAIL sweep_load got=%b want=%b", status_out, 4'(f));
            end
            for (int c = 0; c < 16; c++) begin
                cond_id = 4'(c);
                #1;
                total++;
                if (cond_pass !== exp_pass(4'(c), 4'(f))) begin
                    bad++; $display("FAIL sweep_cond nzcv=%b cond=%b got=%b want=%b",
                                    4'(f), 4'(c), cond_pass, exp_pass(4'(c), 4'(f)));
                end
            end
        end
    endtask

    task automatic test_invalid();
        valid_in = 1'b0; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; s_in = 1'b1;
        alu_res_in = 32'h0BAD_0BAD; set_flags(4'b0001);
        tick();
        total++;
        if ({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out} !== 4'b0000) begin
            bad++; $display("FAIL invalid_ctrl got=%b want=0000", {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out});
        end
        total++;
        if (status_out !== 4'b1111) begin
            bad++; $display("FAIL invalid_status got=%b want=1111", status_out);
        end
        total++;
        if (alu_res_out !== 32'h0BAD_0BAD) begin
            bad++; $display("FAIL invalid_data got=%h want=0bad0bad", alu_res_out);
        end
    endtask

    task automatic test_reset_mid_stall();
        valid_in = 1'b1; s_in = 1'b1; wb_en_in = 1'b1; set_flags(4'b0110);
        tick();
        freeze = 1'b1; flush = 1'b1; rst = 1'b1; set_flags(4'b0000);
        tick();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; valid_in = 1'b0; s_in = 1'b0;
        total++;
        if (valid_out !== 1'b0 || wb_en_out !== 1'b0 || alu_res_out !== 32'h0 || status_out !== 4'b0000) begin
            bad++; $display("FAIL reset_mid_stall got=%b/%b/%h/%b want=0/0/0/0000",
                            valid_out, wb_en_out, alu_res_out, status_out);
        end
    endtask

    initial begin
        test_reset();
        test_capture_s();
        test_no_s();
        test_freeze_flush();
        test_cond_sweep();
        test_invalid();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
